// File: rtl/boot_pkg.sv
// Shared types and constants for the serial boot loader: FSM states,
// record type codes, bus widths and the running-checksum helper.
package boot_pkg;

    localparam int ADDR_W = 23;
    localparam int DATA_W = 16;

    localparam logic [7:0] BOOT_LOAD         = 8'h00;
    localparam logic [7:0] BOOT_RUN          = 8'h01;
    localparam logic [7:0] BOOT_SYNC_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TYPE  = 3'd1,
        ST_ADDR  = 3'd2,
        ST_CNT   = 3'd3,
        ST_DHI   = 3'd4,
        ST_DLO   = 3'd5,
        ST_WRITE = 3'd6,
        ST_SUM   = 3'd7
    } boot_state_e;

    // Modulo-256 accumulation used by the frame checksum.
    function automatic logic [7:0] sum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

    function automatic logic type_ok(input logic [7:0] t);
        return (t == BOOT_LOAD) || (t == BOOT_RUN);
    endfunction

endpackage

// File: rtl/boot_timer.sv
// Loadable down-counter; pulses expire for one cycle in the cycle after
// it counts down to zero while enabled.
module boot_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    output logic             expire
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] count_r;
    logic             expire_r;

    // Countdown register with registered expiry flag
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r  <= ZERO;
            expire_r <= 1'b0;
        end else if (load) begin
            count_r  <= load_value;
            expire_r <= 1'b0;
        end else if (en && (count_r != ZERO)) begin
            count_r  <= count_r - ONE;
            expire_r <= (count_r == ONE);
        end else begin
            expire_r <= 1'b0;
        end
    end

    assign expire = expire_r;

endmodule

// File: rtl/boot_loader.sv
// Framed serial boot loader: parses load records from a byte stream, writes
// 16-bit words to memory and releases the CPU after a good run frame.
module boot_loader
    import boot_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE = BOOT_SYNC_DEFAULT,
    parameter int unsigned TIMEOUT   = 65535
) (
    input  logic              _CLK,
    input  logic              RESET,
    input  logic [7:0]        RX_DATA,
    input  logic              RX_VALID,
    output logic              RX_READY,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_DATA,
    output logic              MEM_WE,
    input  logic              MEM_ACK,
    output logic              CPU_HOLD,
    output logic              DONE,
    output logic              ERROR
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    boot_state_e       state_r, state_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic [DATA_W-1:0] data_r, data_s;
    logic [15:0]       cnt_r, cnt_s;
    logic [7:0]        sum_r, sum_s, byte_sum_s;
    logic [1:0]        idx_r, idx_s;
    logic [7:0]        type_r, type_s;
    logic              we_r, we_s;
    logic              ready_r, ready_s;
    logic              hold_r, hold_s;
    logic              done_r, done_s;
    logic              error_r, error_s;

    logic accept_s;
    logic timer_en_s;
    logic expire_s;
    logic timeout_s;

    assign accept_s   = RX_VALID & ready_r;
    assign timer_en_s = (state_r != ST_IDLE) && (state_r != ST_WRITE);
    assign timeout_s  = expire_s & timer_en_s & ~accept_s;

    generate
        if (TIMEOUT != 0) begin : g_timer
            boot_timer #(.WIDTH(TMR_W)) u_timer (
                .clk        (_CLK),
                .reset      (RESET),
                .load       (accept_s),
                .load_value (TMR_W'(TIMEOUT)),
                .en         (timer_en_s),
                .expire     (expire_s)
            );
        end else begin : g_no_timer
            assign expire_s = 1'b0;
        end
    endgenerate

    // FSM state register
    always_ff @(posedge _CLK) begin
        if (RESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and next-value logic for the frame parser and write port
    always_comb begin
        state_s    = state_r;
        addr_s     = addr_r;
        data_s     = data_r;
        cnt_s      = cnt_r;
        sum_s      = sum_r;
        idx_s      = idx_r;
        type_s     = type_r;
        we_s       = we_r;
        hold_s     = hold_r;
        done_s     = done_r;
        error_s    = error_r;
        byte_sum_s = sum_add(sum_r, RX_DATA);

        if (timeout_s) begin
            error_s = 1'b1;
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && (RX_DATA == SYNC_BYTE)) begin
                        error_s = 1'b0;
                        done_s  = 1'b0;
                        hold_s  = 1'b1;
                        sum_s   = 8'h00;
                        state_s = ST_TYPE;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_TYPE: begin
                    if (accept_s) begin
                        sum_s  = byte_sum_s;
                        type_s = RX_DATA;
                        idx_s  = 2'd0;
                        if (type_ok(RX_DATA)) begin
                            state_s = ST_ADDR;
                        end else begin
                            error_s = 1'b1;
                            state_s = ST_IDLE;
                        end
                    end else begin
                        state_s = ST_TYPE;
                    end
                end
                ST_ADDR: begin
                    if (accept_s) begin
                        sum_s = byte_sum_s;
                        // Top address bit is outside the 23-bit word space.
                        case (idx_r)
                            2'd0:    addr_s[22:16] = RX_DATA[6:0];
                            2'd1:    addr_s[15:8]  = RX_DATA;
                            default: addr_s[7:0]   = RX_DATA;
                        endcase
                        if (idx_r == 2'd2) begin
                            idx_s   = 2'd0;
                            state_s = ST_CNT;
                        end else begin
                            idx_s = idx_r + 2'd1;
                        end
                    end else begin
                        state_s = ST_ADDR;
                    end
                end
                ST_CNT: begin
                    if (accept_s) begin
                        sum_s = byte_sum_s;
                        if (idx_r == 2'd0) begin
                            cnt_s[15:8] = RX_DATA;
                            idx_s       = 2'd1;
                        end else begin
                            cnt_s[7:0] = RX_DATA;
                            idx_s      = 2'd0;
                            state_s    = ({cnt_r[15:8], RX_DATA} == 16'd0) ? ST_SUM : ST_DHI;
                        end
                    end else begin
                        state_s = ST_CNT;
                    end
                end
                ST_DHI: begin
                    if (accept_s) begin
                        sum_s        = byte_sum_s;
                        data_s[15:8] = RX_DATA;
                        state_s      = ST_DLO;
                    end else begin
                        state_s = ST_DHI;
                    end
                end
                ST_DLO: begin
                    if (accept_s) begin
                        sum_s       = byte_sum_s;
                        data_s[7:0] = RX_DATA;
                        we_s        = 1'b1;
                        state_s     = ST_WRITE;
                    end else begin
                        state_s = ST_DLO;
                    end
                end
                ST_WRITE: begin
                    if (we_r && MEM_ACK) begin
                        we_s    = 1'b0;
                        addr_s  = addr_r + 23'd1;
                        cnt_s   = cnt_r - 16'd1;
                        state_s = (cnt_r == 16'd1) ? ST_SUM : ST_DHI;
                    end else begin
                        we_s = 1'b1;
                    end
                end
                ST_SUM: begin
                    if (accept_s) begin
                        sum_s   = byte_sum_s;
                        state_s = ST_IDLE;
                        if (byte_sum_s == 8'h00) begin
                            if (type_r == BOOT_RUN) begin
                                done_s = 1'b1;
                                hold_s = 1'b0;
                            end else begin
                                hold_s = hold_r;
                            end
                        end else begin
                            error_s = 1'b1;
                            hold_s  = 1'b1;
                        end
                    end else begin
                        state_s = ST_SUM;
                    end
                end
                default: begin
                    we_s    = 1'b0;
                    state_s = ST_IDLE;
                end
            endcase
        end

        ready_s = (state_s != ST_WRITE);
    end

    // Datapath and registered output flags
    always_ff @(posedge _CLK) begin
        if (RESET) begin
            addr_r  <= 23'd0;
            data_r  <= 16'd0;
            cnt_r   <= 16'd0;
            sum_r   <= 8'h00;
            idx_r   <= 2'd0;
            type_r  <= 8'h00;
            we_r    <= 1'b0;
            ready_r <= 1'b0;
            hold_r  <= 1'b1;
            done_r  <= 1'b0;
            error_r <= 1'b0;
        end else begin
            addr_r  <= addr_s;
            data_r  <= data_s;
            cnt_r   <= cnt_s;
            sum_r   <= sum_s;
            idx_r   <= idx_s;
            type_r  <= type_s;
            we_r    <= we_s;
            ready_r <= ready_s;
            hold_r  <= hold_s;
            done_r  <= done_s;
            error_r <= error_s;
        end
    end

    assign RX_READY = ready_r;
    assign MEM_ADDR = addr_r;
    assign MEM_DATA = data_r;
    assign MEM_WE   = we_r;
    assign CPU_HOLD = hold_r;
    assign DONE     = done_r;
    assign ERROR    = error_r;

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: directed frames push expected writes,
// a monitor compares every acknowledged memory write.
module tb_boot_loader;

    typedef struct packed {
        logic [22:0] addr;
        logic [15:0] data;
    } wr_t;
    typedef logic [7:0] bytes_t[$];

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [22:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_we;
    logic        mem_ack;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int     checks    = 0;
    int     failures  = 0;
    int     ack_delay = 0;
    wr_t    sb_q[$];
    bytes_t frm;

    boot_loader #(.SYNC_BYTE(8'hA5), .TIMEOUT(8)) dut (
        ._CLK     (clk),
        .RESET    (reset),
        .RX_DATA  (rx_data),
        .RX_VALID (rx_valid),
        .RX_READY (rx_ready),
        .MEM_ADDR (mem_addr),
        .MEM_DATA (mem_data),
        .MEM_WE   (mem_we),
        .MEM_ACK  (mem_ack),
        .CPU_HOLD (cpu_hold),
        .DONE     (done),
        .ERROR    (error)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory responder: acks on the (ack_delay+1)-th cycle of each write request.
    initial begin
        int we_cycles;
        we_cycles = 0;
        mem_ack   = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_we) begin
                mem_ack = (we_cycles == ack_delay);
                we_cycles++;
            end else begin
                mem_ack   = 1'b0;
                we_cycles = 0;
            end
        end
    end

    // Write monitor: pops the scoreboard on every completed write.
    initial begin
        int  we_len;
        wr_t exp;
        we_len = 0;
        forever begin
            @(negedge clk);
            #1;
            if (mem_we && !reset) begin
                we_len++;
                check("rx_ready_low_in_write", {31'd0, rx_ready}, 32'd0);
                if (mem_ack) begin
                    check("we_hold_cycles", we_len, ack_delay + 1);
                    if (sb_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_data);
                    end else begin
                        exp = sb_q.pop_front();
                        check("write_addr", {9'd0, mem_addr}, {9'd0, exp.addr});
                        check("write_data", {16'd0, mem_data}, {16'd0, exp.data});
                    end
                end
            end else begin
                we_len = 0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 64) begin
            checks++;
            failures++;
            $display("FAIL rx_accept_timeout: byte %0h got rx_ready=0 expected 1", b);
        end
        @(posedge clk);
    endtask

    task automatic send_frame(input bytes_t f);
        foreach (f[i]) send_byte(f[i]);
    endtask

    task automatic end_check(input string name, input logic exp_done, input logic exp_err, input logic exp_hold);
        @(negedge clk);
        rx_valid = 1'b0;
        #1;
        check({name, "_done"}, {31'd0, done}, {31'd0, exp_done});
        check({name, "_error"}, {31'd0, error}, {31'd0, exp_err});
        check({name, "_hold"}, {31'd0, cpu_hold}, {31'd0, exp_hold});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", {9'd0, mem_addr}, 32'd0);
        check("rst_mem_data", {16'd0, mem_data}, 32'd0);
        check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("rx_ready_after_reset", {31'd0, rx_ready}, 32'd1);

        // Good run frame: one word, then release.
        ack_delay = 0;
        sb_q.push_back('{addr: 23'h40E000, data: 16'h5800});
        frm = '{8'hA5, 8'h01, 8'h40, 8'hE0, 8'h00, 8'h00, 8'h01, 8'h58, 8'h00, 8'h86};
        send_frame(frm);
        end_check("run_good", 1'b1, 1'b0, 1'b0);

        // Same frame with a bad checksum: write stands, error raised.
        sb_q.push_back('{addr: 23'h40E000, data: 16'h5800});
        frm = '{8'hA5, 8'h01, 8'h40, 8'hE0, 8'h00, 8'h00, 8'h01, 8'h58, 8'h00, 8'h87};
        send_frame(frm);
        end_check("run_badsum", 1'b0, 1'b1, 1'b1);

        // Two words at the top of memory (bit 23 set), slow acks, address wrap.
        ack_delay = 3;
        sb_q.push_back('{addr: 23'h7FFFFF, data: 16'h1234});
        sb_q.push_back('{addr: 23'h000000, data: 16'hABCD});
        frm = '{8'hA5, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
        send_frame(frm);
        end_check("load_wrap", 1'b0, 1'b0, 1'b1);

        // Leading garbage then an illegal type.
        ack_delay = 0;
        frm = '{8'h00, 8'hFF, 8'hA5, 8'h05};
        send_frame(frm);
        end_check("bad_type", 1'b0, 1'b1, 1'b1);

        // Stall after the address bytes until the timer expires.
        frm = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h10};
        send_frame(frm);
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (7) @(negedge clk);
        #1;
        check("timeout_not_yet", {31'd0, error}, 32'd0);
        repeat (2) @(negedge clk);
        #1;
        check("timeout_error", {31'd0, error}, 32'd1);
        check("timeout_hold", {31'd0, cpu_hold}, 32'd1);

        // Following frame loads normally; embedded A5 bytes are plain data.
        sb_q.push_back('{addr: 23'h000005, data: 16'hA5A5});
        frm = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h01, 8'hA5, 8'hA5, 8'hB0};
        send_frame(frm);
        end_check("after_timeout", 1'b0, 1'b0, 1'b1);

        // Zero-length run frame releases the CPU without writes.
        frm = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
        send_frame(frm);
        end_check("run_cnt0", 1'b1, 1'b0, 1'b0);

        // Reset while a write is pending.
        ack_delay = 20;
        frm = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h01, 8'h11, 8'h22};
        send_frame(frm);
        g = 0;
        @(negedge clk);
        rx_valid = 1'b0;
        while (!mem_we && g < 16) begin
            @(negedge clk);
            g++;
        end
        check("we_before_reset", {31'd0, mem_we}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("rst_write_we", {31'd0, mem_we}, 32'd0);
        check("rst_write_hold", {31'd0, cpu_hold}, 32'd1);
        check("rst_write_ready", {31'd0, rx_ready}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("rst_write_ready_back", {31'd0, rx_ready}, 32'd1);

        repeat (2) @(negedge clk);
        check("scoreboard_drain", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
